// File: rtl/core_pkg.sv
// Shared constants for the RV32I front-end pipeline: NOP encoding, reset PC and
// the bit layout of the packed decode-control bus.
package core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int CTRL_ALUSRC    = 0;
    localparam int CTRL_ALUCTRL   = 1;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_JUMP      = 5;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_RESULTSRC = 7;
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_W         = 10;

    function automatic logic [CTRL_W-1:0] ctrl_pack(
        input logic       regwrite,
        input logic [1:0] resultsrc,
        input logic       memwrite,
        input logic       jump,
        input logic       branch,
        input logic [2:0] alucontrol,
        input logic       alusrc
    );
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_REGWRITE]            = regwrite;
        c[CTRL_RESULTSRC +: 2]      = resultsrc;
        c[CTRL_MEMWRITE]            = memwrite;
        c[CTRL_JUMP]                = jump;
        c[CTRL_BRANCH]              = branch;
        c[CTRL_ALUCTRL +: 3]        = alucontrol;
        c[CTRL_ALUSRC]              = alusrc;
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset, then synchronous clear to the same
// value (bubble), then load on enable.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/front_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I core, driven by the hazard
// unit's stall/flush/redirect controls, plus saturating stall/flush counters.
module front_pipe_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 10,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    input  logic [31:0]       InstrF,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    import core_pkg::*;

    localparam int IFID_W = 32 + 32 + 32 + 1;
    localparam int IDEX_W = CTRL_W + 5 * 32 + 3 * 5 + 1;
    localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, 64'h0, 1'b0};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [31:0]       pc_plus4_f;
    logic [31:0]       pc_d;
    logic              pc_en;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;
    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

    // Fetch: redirect outranks stall so a misbehaving hazard unit cannot lose a branch.
    assign pc_plus4_f = PCF + 32'd4;
    assign pc_d       = PCSrcE ? PCTargetE : pc_plus4_f;
    assign pc_en      = PCSrcE | ~StallF;

    pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .clr   (1'b0),
        .d     (pc_d),
        .q     (PCF)
    );

    // IF/ID: the bubble value doubles as the reset value (NOP, invalid).
    assign ifid_d = {InstrF, PCF, pc_plus4_f, 1'b1};

    pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;

    // ID/EX never stalls; a held Decode slot is covered by FlushE injecting a bubble.
    assign idex_d = {CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                     InstrD[19:15], InstrD[24:20], InstrD[11:7], ValidD};

    pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (idex_d),
        .q     (idex_q)
    );

    assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = idex_q;

    // A stall that coincides with a flush is not a real stall cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && !FlushD) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (FlushE) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule
